// File: rtl/sha1_iter_scheduler_if.sv
// Job, pipeline and result signals of the SHA-1 iteration scheduler.
// Job handshake: a job transfers on a rising clk edge where job_valid && job_ready are both high;
// job_* must be stable while job_valid is high, and job_ready may depend on state but never on job_valid.
interface sha1_iter_scheduler_if #(
  parameter int TAG_W = 7
);
  logic             job_valid;
  logic             job_ready;
  logic [TAG_W-1:0] job_tag;
  logic [159:0]     job_iv;
  logic [511:0]     job_msg;
  logic [15:0]      job_iters;

  logic [511:0]     p_msg;
  logic [31:0]      p_a;
  logic [31:0]      p_b;
  logic [31:0]      p_c;
  logic [31:0]      p_d;
  logic [31:0]      p_e;

  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_c;
  logic [31:0]      r_d;
  logic [31:0]      r_e;

  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic [159:0]     res_digest;

  // Requester plus compression pipeline side.
  modport master (
    output job_valid, job_tag, job_iv, job_msg, job_iters,
    input  job_ready,
    input  p_msg, p_a, p_b, p_c, p_d, p_e,
    output r_a, r_b, r_c, r_d, r_e,
    input  res_valid, res_tag, res_digest
  );

  // Scheduler side.
  modport slave (
    input  job_valid, job_tag, job_iv, job_msg, job_iters,
    output job_ready,
    output p_msg, p_a, p_b, p_c, p_d, p_e,
    input  r_a, r_b, r_c, r_d, r_e,
    output res_valid, res_tag, res_digest
  );
endinterface

// File: rtl/sha1_iter_scheduler.sv
// Slot scheduler for a fully unrolled SHA-1 pipeline: admits jobs, recirculates each digest
// (feed-forward add plus re-padding) as the next block, and emits it when its count expires.
module sha1_iter_scheduler #(
  parameter int LAT      = 82,
  parameter int TAG_W    = 7,
  parameter int LEN_BITS = 672
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  sha1_iter_scheduler_if.slave bus,
  output logic                 busy,
  output logic [7:0]           inflight
);
  localparam logic [31:0] LEN_WORD = 32'(LEN_BITS);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [15:0]      remain;
  } meta_t;

  meta_t            meta_q [LAT];
  meta_t            meta_d [LAT];
  logic [511:0]     p_msg_q, p_msg_d;
  logic [159:0]     p_st_q, p_st_d;
  logic             res_valid_q, res_valid_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [159:0]     res_digest_q, res_digest_d;
  logic [7:0]       inflight_q, inflight_d;

  // IV per tag; read by returning jobs, written on insert. Not reset.
  logic [159:0]     iv_mem [2**TAG_W];

  meta_t            tap;
  logic [159:0]     iv_rd;
  logic [159:0]     digest;
  logic             recirc;
  logic             retire;
  logic             ready;
  logic             insert;
  logic [15:0]      iters_m1;

  always_comb begin
    tap      = meta_q[LAT-1];
    iv_rd    = iv_mem[tap.tag];
    digest   = {bus.r_a + iv_rd[159:128],
                bus.r_b + iv_rd[127:96],
                bus.r_c + iv_rd[95:64],
                bus.r_d + iv_rd[63:32],
                bus.r_e + iv_rd[31:0]};
    recirc   = tap.valid && (tap.remain != 16'd0);
    retire   = tap.valid && (tap.remain == 16'd0);
    // A retiring slot is immediately reusable by a new job in the same cycle.
    ready    = rst_n && !recirc && !flush;
    insert   = bus.job_valid && ready;
    iters_m1 = (bus.job_iters == 16'd0) ? 16'd0 : bus.job_iters - 16'd1;
  end

  always_comb begin
    meta_d[0] = '0;
    p_msg_d   = '0;
    p_st_d    = '0;
    for (int i = 1; i < LAT; i++) begin
      meta_d[i] = meta_q[i-1];
    end

    if (recirc) begin
      meta_d[0].valid  = 1'b1;
      meta_d[0].tag    = tap.tag;
      meta_d[0].remain = tap.remain - 16'd1;
      p_msg_d          = {digest, 32'h8000_0000, 288'd0, LEN_WORD};
      p_st_d           = iv_rd;
    end else if (insert) begin
      meta_d[0].valid  = 1'b1;
      meta_d[0].tag    = bus.job_tag;
      meta_d[0].remain = iters_m1;
      p_msg_d          = bus.job_msg;
      p_st_d           = bus.job_iv;
    end

    // Flush invalidates the whole line; whatever the pipeline returns later is a bubble.
    if (flush) begin
      for (int i = 0; i < LAT; i++) begin
        meta_d[i] = '0;
      end
      p_msg_d = '0;
      p_st_d  = '0;
    end

    res_valid_d  = retire && !flush;
    res_tag_d    = res_valid_d ? tap.tag : '0;
    res_digest_d = res_valid_d ? digest : '0;

    if (flush) begin
      inflight_d = 8'd0;
    end else begin
      inflight_d = inflight_q + {7'd0, insert} - {7'd0, retire};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        meta_q[i] <= '0;
      end
      p_msg_q      <= '0;
      p_st_q       <= '0;
      res_valid_q  <= 1'b0;
      res_tag_q    <= '0;
      res_digest_q <= '0;
      inflight_q   <= 8'd0;
    end else begin
      for (int i = 0; i < LAT; i++) begin
        meta_q[i] <= meta_d[i];
      end
      p_msg_q      <= p_msg_d;
      p_st_q       <= p_st_d;
      res_valid_q  <= res_valid_d;
      res_tag_q    <= res_tag_d;
      res_digest_q <= res_digest_d;
      inflight_q   <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (insert) begin
      iv_mem[bus.job_tag] <= bus.job_iv;
    end
  end

  assign bus.job_ready  = ready;
  assign bus.p_msg      = p_msg_q;
  assign bus.p_a        = p_st_q[159:128];
  assign bus.p_b        = p_st_q[127:96];
  assign bus.p_c        = p_st_q[95:64];
  assign bus.p_d        = p_st_q[63:32];
  assign bus.p_e        = p_st_q[31:0];
  assign bus.res_valid  = res_valid_q;
  assign bus.res_tag    = res_tag_q;
  assign bus.res_digest = res_digest_q;
  assign busy           = (inflight_q != 8'd0);
  assign inflight       = inflight_q;
endmodule

// File: tb/tb_sha1_iter_scheduler.sv
// Bench for sha1_iter_scheduler: behavioural SHA-1 pipeline of LAT-1 stages behind the
// registered p_* outputs, expected digests queued on insert and compared on res_valid.
module tb_sha1_iter_scheduler;
  localparam int LAT      = 82;
  localparam int TAG_W    = 7;
  localparam int LEN_BITS = 672;
  localparam int EW       = TAG_W + 160 + 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       busy;
  logic [7:0] inflight;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [EW-1:0] exp_q[$];

  sha1_iter_scheduler_if #(.TAG_W(TAG_W)) bus();

  sha1_iter_scheduler #(.LAT(LAT), .TAG_W(TAG_W), .LEN_BITS(LEN_BITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .busy     (busy),
    .inflight (inflight)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SHA-1 reference ----------------
  function automatic logic [159:0] sha1_rounds(input logic [159:0] st, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t, x;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      x    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {x[30:0], x[31]};
    end
    {a, b, c, d, e} = st;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);         k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                  k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                  k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {a, b, c, d, e};
  endfunction

  function automatic logic [159:0] add5(input logic [159:0] x, input logic [159:0] y);
    logic [159:0] s;
    for (int i = 0; i < 5; i++) s[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return s;
  endfunction

  function automatic logic [159:0] model_digest(input logic [159:0] iv, input logic [511:0] msg,
                                                input logic [15:0] iters);
    logic [159:0] d;
    logic [31:0]  len;
    int           n;
    len = LEN_BITS;
    n   = (iters == 16'd0) ? 1 : int'(iters);
    d   = add5(sha1_rounds(iv, msg), iv);
    for (int i = 1; i < n; i++) d = add5(sha1_rounds(iv, {d, 32'h8000_0000, 288'd0, len}), iv);
    return d;
  endfunction

  // Compression pipeline: LAT-1 stages after the DUT's own p_* register.
  logic [159:0] pipe [LAT-1];
  always @(posedge clk) begin
    pipe[0] <= sha1_rounds({bus.p_a, bus.p_b, bus.p_c, bus.p_d, bus.p_e}, bus.p_msg);
    for (int i = 1; i < LAT-1; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.r_a = pipe[LAT-2][159:128];
  assign bus.r_b = pipe[LAT-2][127:96];
  assign bus.r_c = pipe[LAT-2][95:64];
  assign bus.r_d = pipe[LAT-2][63:32];
  assign bus.r_e = pipe[LAT-2][31:0];

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: entries are {tag, digest, expected res_valid cycle}.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && bus.res_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("res_unexpected", 256'(bus.res_valid), 256'(1'b0));
      end else begin
        e = exp_q.pop_front();
        check_eq("res_tag", 256'(bus.res_tag), 256'(e[EW-1:192]));
        check_eq("res_digest", 256'(bus.res_digest), 256'(e[191:32]));
        check_eq("res_latency", 256'(cyc), 256'(e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic try_insert(input logic [TAG_W-1:0] tag, input logic [159:0] iv,
                            input logic [511:0] msg, input logic [15:0] iters,
                            input logic [159:0] exp_d, input bit push, output int acc);
    int n_eff;
    n_eff = (iters == 16'd0) ? 1 : int'(iters);
    acc   = -1;
    for (int k = 0; k < 400 && acc < 0; k++) begin
      @(negedge clk);
      bus.job_valid = 1'b1;
      bus.job_tag   = tag;
      bus.job_iv    = iv;
      bus.job_msg   = msg;
      bus.job_iters = iters;
      #1;
      if (bus.job_ready) begin
        acc = cyc;
        if (push) exp_q.push_back({tag, exp_d, 32'(cyc + n_eff*LAT + 1)});
      end
    end
    if (acc < 0) check_eq("insert_timeout", 256'(bus.job_ready), 256'(1'b1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.job_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) idle(1);
    check_eq("drain_done", 256'(exp_q.size()), 256'(0));
  endtask

  function automatic logic [159:0] rand_iv();
    logic [159:0] v;
    for (int i = 0; i < 5; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [511:0] rand_msg();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // ---------------- stimulus ----------------
  logic [159:0] abc_iv;
  logic [511:0] abc_msg;
  logic [159:0] iv;
  logic [511:0] msg;
  int           acc, c0, ca;

  initial begin
    abc_iv  = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    abc_msg = {32'h61626380, 448'd0, 32'h00000018};
    rst_n = 1'b0; flush = 1'b0;
    bus.job_valid = 1'b0; bus.job_tag = '0; bus.job_iv = '0; bus.job_msg = '0; bus.job_iters = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_res_valid", 256'(bus.res_valid), 256'(0));
    check_eq("rst_res_tag", 256'(bus.res_tag), 256'(0));
    check_eq("rst_res_digest", 256'(bus.res_digest), 256'(0));
    check_eq("rst_p_msg", 256'(bus.p_msg), 256'(0));
    check_eq("rst_p_a", 256'(bus.p_a), 256'(0));
    check_eq("rst_inflight", 256'(inflight), 256'(0));
    check_eq("rst_busy", 256'(busy), 256'(0));
    check_eq("rst_job_ready", 256'(bus.job_ready), 256'(0));
    rst_n = 1'b1;
    idle(2);

    // "abc", one compression
    try_insert(7'h2A, abc_iv, abc_msg, 16'd1,
               160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, 1'b1, acc);
    idle(1); #1;
    check_eq("abc_inflight", 256'(inflight), 256'(1));
    check_eq("abc_busy", 256'(busy), 256'(1));
    check_eq("abc_p_a", 256'(bus.p_a), 256'(32'h67452301));
    check_eq("abc_p_msg", 256'(bus.p_msg), 256'(abc_msg));
    wait_drain(LAT + 20);
    idle(1); #1;
    check_eq("abc_inflight_end", 256'(inflight), 256'(0));

    // "abc", two compressions
    try_insert(7'h2B, abc_iv, abc_msg, 16'd2, model_digest(abc_iv, abc_msg, 16'd2), 1'b1, acc);
    wait_drain(2*LAT + 20);

    // LAT+5 back-to-back jobs, three compressions each
    for (int i = 0; i < LAT + 5; i++) begin
      if (i == LAT) begin
        @(negedge clk); #1;
        check_eq("b2b_inflight_full", 256'(inflight), 256'(LAT));
        check_eq("b2b_ready_low", 256'(bus.job_ready), 256'(0));
      end
      iv  = rand_iv();
      msg = rand_msg();
      try_insert(TAG_W'(i), iv, msg, 16'd3, model_digest(iv, msg, 16'd3), 1'b1, acc);
      if (i == 0) c0 = acc;
      if (i == LAT-1) check_eq("b2b_consecutive", 256'(acc), 256'(c0 + LAT - 1));
      if (i == LAT) check_eq("b2b_ready_return", 256'(acc), 256'(c0 + 3*LAT));
    end
    idle(1);
    wait_drain(7*LAT);

    // Retire/insert collision
    iv = rand_iv(); msg = rand_msg();
    try_insert(7'd1, iv, msg, 16'd1, model_digest(iv, msg, 16'd1), 1'b1, ca);
    for (int k = 0; k < 200 && cyc < ca + LAT - 1; k++) idle(1);
    iv = rand_iv(); msg = rand_msg();
    try_insert(7'd2, iv, msg, 16'd1, model_digest(iv, msg, 16'd1), 1'b1, acc);
    check_eq("coll_accept_cycle", 256'(acc), 256'(ca + LAT));
    idle(1); #1;
    check_eq("coll_pulse", 256'(bus.res_valid), 256'(1));
    check_eq("coll_inflight", 256'(inflight), 256'(1));
    wait_drain(LAT + 20);

    // Flush with 40 slots busy
    for (int i = 0; i < 40; i++) begin
      iv = rand_iv(); msg = rand_msg();
      try_insert(TAG_W'(i), iv, msg, 16'd3, '0, 1'b0, acc);
      if (i == 0) c0 = acc;
    end
    idle(1);
    for (int k = 0; k < 200 && cyc < c0 + 100; k++) idle(1);
    @(negedge clk);
    flush = 1'b1;
    bus.job_valid = 1'b1;
    #1;
    check_eq("flush_ready_low", 256'(bus.job_ready), 256'(0));
    check_eq("flush_inflight_before", 256'(inflight), 256'(40));
    @(negedge clk);
    flush = 1'b0;
    bus.job_valid = 1'b0;
    #1;
    check_eq("flush_inflight_after", 256'(inflight), 256'(0));
    check_eq("flush_busy_after", 256'(busy), 256'(0));
    iv = rand_iv(); msg = rand_msg();
    try_insert(7'd100, iv, msg, 16'd3, model_digest(iv, msg, 16'd3), 1'b1, acc);
    wait_drain(3*LAT + 20);
    idle(LAT);

    // Reset pulsed during recirculation
    for (int i = 0; i < 20; i++) begin
      iv = rand_iv(); msg = rand_msg();
      try_insert(TAG_W'(i), iv, msg, 16'd2, '0, 1'b0, acc);
    end
    idle(100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_res_valid", 256'(bus.res_valid), 256'(0));
    check_eq("mid_rst_p_msg", 256'(bus.p_msg), 256'(0));
    check_eq("mid_rst_p_e", 256'(bus.p_e), 256'(0));
    check_eq("mid_rst_inflight", 256'(inflight), 256'(0));
    check_eq("mid_rst_busy", 256'(busy), 256'(0));
    check_eq("mid_rst_job_ready", 256'(bus.job_ready), 256'(0));
    idle(3);
    rst_n = 1'b1;
    iv = rand_iv(); msg = rand_msg();
    try_insert(7'd5, iv, msg, 16'd0, model_digest(iv, msg, 16'd1), 1'b1, acc);
    wait_drain(LAT + 20);
    idle(2*LAT + 30);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
